// File: rtl/serial_adder8.sv
// Bit-serial two's-complement adder: one full-adder cell and a registered carry,
// WIDTH clocks per add behind a start/done handshake, with carry-out and signed overflow flags.
module serial_adder8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SUM_W = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   sh_a;
  logic [WIDTH-1:0]   sh_b;
  logic [SUM_W-1:0]   sh_s;
  logic               carry;
  logic               cin_msb;
  logic [CNT_W-1:0]   cnt;
  logic               s_bit_c;
  logic               c_next_c;
  logic               last_c;
  logic               pre_msb_c;

  // Single full-adder cell over the current LSBs and the registered carry.
  always_comb begin
    s_bit_c   = sh_a[0] ^ sh_b[0] ^ carry;
    c_next_c  = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    last_c    = (cnt == CNT_W'(WIDTH - 1));
    pre_msb_c = (cnt == CNT_W'(WIDTH - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand/sum shifters, carry and counter; result registers load only on RUN->DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_s     <= '0;
      carry    <= 1'b0;
      cin_msb  <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          // The sum bit enters at the top; the shifter holds the low WIDTH-1 bits.
          sh_s  <= SUM_W'({s_bit_c, sh_s} >> 1);
          carry <= c_next_c;
          cnt   <= cnt + CNT_W'(1);
          if (pre_msb_c) begin
            cin_msb <= c_next_c;
          end
          if (last_c) begin
            sum      <= {s_bit_c, sh_s};
            carryout <= c_next_c;
            overflow <= cin_msb ^ c_next_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder8.sv
// Directed test of serial_adder8: reset, arithmetic corner cases, ignored starts
// and a reset that aborts an add in flight.
module tb_serial_adder8;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;
  logic             busy;
  logic             done;

  int n_cmp;
  int n_err;
  int n_done;
  logic [WIDTH-1:0] prev_sum;
  logic             prev_c;
  logic             prev_v;

  serial_adder8 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_sum"}, 32'(sum), 32'(prev_sum));
    chk({tag, "_c"}, 32'(carryout), 32'(prev_c));
    chk({tag, "_v"}, 32'(overflow), 32'(prev_v));
  endtask

  // Launch one add, check busy/done timing, held outputs during RUN and the result.
  task automatic run_add(input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic [7:0] exp_sum, input logic exp_c, input logic exp_v,
                         input string tag);
    a = op_a;
    b = op_b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk_held({tag, "_hold"});
      a = 8'(op_a ^ 8'(i * 37 + 5));
      b = 8'(op_b + 8'(i * 11 + 3));
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, "_c"}, 32'(carryout), 32'(exp_c));
    chk({tag, "_v"}, 32'(overflow), 32'(exp_v));
    prev_sum = exp_sum;
    prev_c = exp_c;
    prev_v = exp_v;
    tick();
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk_held({tag, "_after"});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    prev_sum = 8'h00;
    prev_c = 1'b0;
    prev_v = 1'b0;

    // Reset for two cycles, then idle with no done.
    tick();
    tick();
    rst = 1'b0;
    chk("rst_sum", 32'(sum), 32'h00);
    chk("rst_c", 32'(carryout), 32'd0);
    chk("rst_v", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("idle_no_done", 32'(n_done), 32'd0);

    run_add(8'h25, 8'h13, 8'h38, 1'b0, 1'b0, "add_25_13");
    run_add(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run_add(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_add(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, "add_80_80");
    run_add(8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0, "add_c0_c0");

    // Extra starts at E3 (RUN) and E9 (DONE) must be ignored.
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    for (int k = 1; k <= 14; k++) begin
      start = (k == 3 || k == 9);
      a = 8'hFF;
      b = 8'hFF;
      tick();
      start = 1'b0;
      if (done) n_done++;
      if (k < 8) chk_held("haz_hold");
      if (k == 8) begin
        chk("haz_done", 32'(done), 32'd1);
        chk("haz_sum", 32'(sum), 32'h30);
        chk("haz_c", 32'(carryout), 32'd0);
        chk("haz_v", 32'(overflow), 32'd0);
      end
      if (k == 9) chk("haz_idle", 32'(busy), 32'd0);
    end
    chk("haz_one_done", 32'(n_done), 32'd1);
    prev_sum = 8'h30;
    prev_c = 1'b0;
    prev_v = 1'b0;

    // Reset at the 4th RUN edge aborts the add.
    a = 8'h7F;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_sum", 32'(sum), 32'h00);
    chk("abort_c", 32'(carryout), 32'd0);
    chk("abort_v", 32'(overflow), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    prev_sum = 8'h00;
    prev_c = 1'b0;
    prev_v = 1'b0;
    run_add(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, "add_01_02");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
